branch_update_queue: RTL

//  Producer side of the predictor update interface. Takes resolved branches from EX and flags

---
 rtl/branch_update_queue_pkg.sv | 24 ++
 rtl/bpu_update_fifo.sv | 51 +++++
 rtl/branch_update_queue.sv | 105 ++++++++++
 3 files changed

// File: rtl/branch_update_queue_pkg.sv
// Shared types and entry layout for the branch update queue.
// Entry packs {pc, target, taken}; the field offsets below describe that packing.
package branch_update_queue_pkg;

  localparam int DEPTH               = 4;
  localparam int PTR_WIDTH           = 2;
  localparam int BPU_UPD_ENTRY_WIDTH = 65;
  localparam int BPU_UPD_PC          = 33;
  localparam int BPU_UPD_TGT         = 1;
  localparam int BPU_UPD_TAKEN       = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
  } upd_entry_t;

  function automatic logic [31:0] correct_next_pc(input logic        taken,
                                                  input logic [31:0] pc,
                                                  input logic [31:0] target);
    return taken ? target : pc + 32'd4;
  endfunction

endpackage

// File: rtl/bpu_update_fifo.sv
// Generic circular FIFO, one entry per cycle in and out; push ignored when full, pop ignored when empty.
// Head is combinational from storage; push and pop may coincide at any non-full, non-empty count.
module bpu_update_fifo #(
  parameter int WIDTH     = 65,
  parameter int DEPTH     = 4,
  parameter int PTR_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [WIDTH-1:0]     push_dat,
  input  logic                 pop,
  output logic [WIDTH-1:0]     head_dat,
  output logic                 full,
  output logic                 empty,
  output logic [PTR_WIDTH:0]   count
);

  localparam logic [PTR_WIDTH:0] FULL_CNT = DEPTH[PTR_WIDTH:0];

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr;
  logic                 do_push;
  logic                 do_pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  // Pointers are exactly log2(DEPTH) wide, so increment wraps on its own.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/branch_update_queue.sv
// Queues resolved branches for the predictor (2-cycle min latency, stalls on update_stall_i) and
// emits a registered mispredict redirect; ready drops when full. BRANCH_UPDATE_STATS_EN adds perf counters.
module branch_update_queue
  import branch_update_queue_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        resolve_valid_i,
  output logic        resolve_ready_o,
  input  logic [31:0] resolve_pc_i,
  input  logic        resolve_taken_i,
  input  logic [31:0] resolve_target_i,
  input  logic        pred_taken_i,
  input  logic [31:0] pred_target_i,
  input  logic        update_stall_i,
  output logic        branch_valid_o,
  output logic        branch_taken_o,
  output logic [31:0] branch_pc_o,
  output logic [31:0] branch_target_address_o,
`ifdef BRANCH_UPDATE_STATS_EN
  output logic [31:0] perf_branch_cnt_o,
  output logic [31:0] perf_mispredict_cnt_o,
`endif
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o
);

  localparam logic [PTR_WIDTH:0] FULL_CNT = DEPTH[PTR_WIDTH:0];

  logic                           push;
  logic                           pop;
  logic                           fifo_full;
  logic                           fifo_empty;
  logic [PTR_WIDTH:0]             fifo_count;
  logic [BPU_UPD_ENTRY_WIDTH-1:0] push_dat;
  upd_entry_t                     head;
  logic                           mispredict;

  assign resolve_ready_o = (fifo_count != FULL_CNT);
  assign push            = resolve_valid_i && !fifo_full;
  assign pop             = !fifo_empty && !update_stall_i;

  always_comb begin
    push_dat                     = '0;
    push_dat[BPU_UPD_PC +: 32]   = resolve_pc_i;
    push_dat[BPU_UPD_TGT +: 32]  = resolve_target_i;
    push_dat[BPU_UPD_TAKEN]      = resolve_taken_i;
  end

  // Target mismatch only matters when the branch was actually taken.
  assign mispredict = push && ((resolve_taken_i != pred_taken_i) ||
                               (resolve_taken_i && (resolve_target_i != pred_target_i)));

  bpu_update_fifo #(
    .WIDTH     (BPU_UPD_ENTRY_WIDTH),
    .DEPTH     (DEPTH),
    .PTR_WIDTH (PTR_WIDTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .head_dat (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      branch_valid_o          <= 1'b0;
      branch_taken_o          <= 1'b0;
      branch_pc_o             <= '0;
      branch_target_address_o <= '0;
      redirect_valid_o        <= 1'b0;
      redirect_pc_o           <= '0;
    end else begin
      branch_valid_o   <= pop;
      redirect_valid_o <= mispredict;
      if (pop) begin
        branch_taken_o          <= head.taken;
        branch_pc_o             <= head.pc;
        branch_target_address_o <= head.target;
      end
      if (mispredict)
        redirect_pc_o <= correct_next_pc(resolve_taken_i, resolve_pc_i, resolve_target_i);
    end
  end

`ifdef BRANCH_UPDATE_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_branch_cnt_o     <= '0;
      perf_mispredict_cnt_o <= '0;
    end else begin
      if (push && (perf_branch_cnt_o != 32'hFFFF_FFFF))
        perf_branch_cnt_o <= perf_branch_cnt_o + 32'd1;
      if (mispredict && (perf_mispredict_cnt_o != 32'hFFFF_FFFF))
        perf_mispredict_cnt_o <= perf_mispredict_cnt_o + 32'd1;
    end
  end
`endif

endmodule
